reg_bank: RTL and testbench

Eight-entry general-purpose register bank for the lecture datapath. It holds eight `DATA_W`-bit registers and presents all eight in parallel on `r0`..`r7`, which wire straight into the 8-way operand selector's `in0`..`in7`. Writes arrive from the writeback path through a valid/ready handshake. A sequenced clear command walks all entries to zero over eight cycles.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_cell.sv | 24 ++
 rtl/reg_bank.sv | 111 +++++++++++
 tb/tb_reg_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared widths, FSM encodings and counter helpers for the eight-entry register bank.
package reg_bank_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_N   = 8;
    localparam int REG_A_W = 3;

    typedef enum logic {
        RB_IDLE  = 1'b0,
        RB_CLEAR = 1'b1
    } rb_state_e;

    localparam logic [7:0]         WR_CNT_MAX = 8'd255;
    localparam logic [REG_A_W-1:0] PTR_LAST   = REG_A_W'(REG_N - 1);

    // Accepted-write counter holds at its ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == WR_CNT_MAX) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// reg_cell: one data register plus its dirty flag; clear wins over write.
module reg_cell
    import reg_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              dirty
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q     <= '0;
            dirty <= 1'b0;
        end else if (we) begin
            q     <= d;
            dirty <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Eight-entry register bank with handshaked writes and an eight-cycle clear walk.
// Optional combinational write bypass on the r outputs: define REG_BANK_BYPASS_EN.
module reg_bank
    import reg_bank_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [REG_A_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic [DATA_W-1:0]  r0,
    output logic [DATA_W-1:0]  r1,
    output logic [DATA_W-1:0]  r2,
    output logic [DATA_W-1:0]  r3,
    output logic [DATA_W-1:0]  r4,
    output logic [DATA_W-1:0]  r5,
    output logic [DATA_W-1:0]  r6,
    output logic [DATA_W-1:0]  r7,
    output logic [REG_N-1:0]   dirty,
    output logic [7:0]         wr_cnt
);

    rb_state_e                      state, nstate;
    logic [REG_A_W-1:0]             ptr, nptr;
    logic                           wr_acc;
    logic                           clr_last;
    logic [REG_N-1:0]               we, clr;
    logic [REG_N-1:0][DATA_W-1:0]   rq, rout;

    // FSM and clear pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RB_IDLE;
            ptr   <= '0;
        end else begin
            state <= nstate;
            ptr   <= nptr;
        end
    end

    always_comb begin
        nstate   = state;
        nptr     = ptr;
        wr_ready = 1'b0;
        clr_busy = 1'b0;
        case (state)
            RB_IDLE: begin
                wr_ready = 1'b1;
                if (clr_req) begin
                    nstate = RB_CLEAR;
                    nptr   = '0;
                end
            end
            RB_CLEAR: begin
                clr_busy = 1'b1;
                nptr     = ptr + 1'b1;
                if (ptr == PTR_LAST) nstate = RB_IDLE;
            end
            default: nstate = RB_IDLE;
        endcase
    end

    assign wr_acc   = wr_valid && wr_ready;
    assign clr_last = clr_busy && (ptr == PTR_LAST);

    genvar i;
    generate
        for (i = 0; i < REG_N; i++) begin : g_cell
            assign we[i]  = wr_acc   && (wr_addr == REG_A_W'(i));
            assign clr[i] = clr_busy && (ptr     == REG_A_W'(i));

            reg_cell u_cell (
                .clk   (clk),
                .rst   (rst),
                .we    (we[i]),
                .clr   (clr[i]),
                .d     (wr_data),
                .q     (rq[i]),
                .dirty (dirty[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr_last) wr_cnt <= '0;
        else if (wr_acc)     wr_cnt <= sat_inc(wr_cnt);
    end

`ifdef REG_BANK_BYPASS_EN
    // Accepted write data is forwarded to its output in the acceptance cycle.
    always_comb begin
        rout = rq;
        if (wr_acc) rout[wr_addr] = wr_data;
    end
`else
    assign rout = rq;
`endif

    assign r0 = rout[0];
    assign r1 = rout[1];
    assign r2 = rout[2];
    assign r3 = rout[3];
    assign r4 = rout[4];
    assign r5 = rout[5];
    assign r6 = rout[6];
    assign r7 = rout[7];

endmodule

// File: tb/tb_reg_bank.sv
// Randomized and directed bench for reg_bank against a cycle-level behavioural model.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst, wr_valid, clr_req;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready, clr_busy;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0]  dirty, wr_cnt;
    logic [15:0] rv [8];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_reg [8];
    logic [7:0]  m_dirty;
    int          m_cnt;
    int          clr_left;   // CLEAR cycles still to run

    always #5 clk = ~clk;

    reg_bank dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .dirty(dirty), .wr_cnt(wr_cnt)
    );

    assign rv[0] = r0; assign rv[1] = r1; assign rv[2] = r2; assign rv[3] = r3;
    assign rv[4] = r4; assign rv[5] = r5; assign rv[6] = r6; assign rv[7] = r7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_reg[k] = '0;
        m_dirty  = '0;
        m_cnt    = 0;
        clr_left = 0;
    endtask

    function automatic logic [15:0] exp_r(input int k);
`ifdef REG_BANK_BYPASS_EN
        if (clr_left == 0 && wr_valid && wr_addr == 3'(k)) return wr_data;
`endif
        return m_reg[k];
    endfunction

    task automatic check_all();
        for (int k = 0; k < 8; k++) chk($sformatf("r%0d", k), 32'(rv[k]), 32'(exp_r(k)));
        chk("dirty",    32'(dirty),    32'(m_dirty));
        chk("wr_cnt",   32'(wr_cnt),   32'(m_cnt));
        chk("wr_ready", 32'(wr_ready), 32'(clr_left == 0));
        chk("clr_busy", 32'(clr_busy), 32'(clr_left != 0));
    endtask

    // Inputs are set at a negedge; outputs are checked 1ns later, then the edge is modelled.
    task automatic step();
        bit acc;
        int idx;
        #1 check_all();
        acc = (clr_left == 0) && wr_valid;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (clr_left != 0) begin
            idx = 8 - clr_left;
            m_reg[idx]   = '0;
            m_dirty[idx] = 1'b0;
            if (idx == 7) m_cnt = 0;
            clr_left--;
        end else begin
            if (acc) begin
                m_reg[wr_addr]   = wr_data;
                m_dirty[wr_addr] = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (clr_req) clr_left = 8;
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        wr_valid = 0; clr_req = 0; rst = 0;
    endtask

    initial begin
        int busy_cycles;
        logic [15:0] old5;

        rst = 1; wr_valid = 0; clr_req = 0; wr_addr = 0; wr_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 0;

        // Reset state
        #1;
        chk("rst_r3", 32'(r3), 32'h0);
        chk("rst_dirty", 32'(dirty), 32'h0);
        chk("rst_cnt", 32'(wr_cnt), 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'h1);
        chk("rst_busy", 32'(clr_busy), 32'h0);
        step();

        // Two back-to-back writes
        wr_valid = 1; wr_addr = 3; wr_data = 16'hA5A5; step();
        wr_addr = 7; wr_data = 16'h1234; step();
        idle_in();
        #1;
        chk("w2_r3", 32'(r3), 32'hA5A5);
        chk("w2_r7", 32'(r7), 32'h1234);
        chk("w2_dirty", 32'(dirty), 32'h88);
        chk("w2_cnt", 32'(wr_cnt), 32'd2);
        step();

        // Fill, clear, with a write held across the clear
        for (int k = 0; k < 8; k++) begin
            wr_valid = 1; wr_addr = 3'(k); wr_data = 16'($urandom); step();
        end
        wr_valid = 1; wr_addr = 0; wr_data = 16'hFFFF; clr_req = 1; step();
        clr_req = 0;
        busy_cycles = 0;
        for (int k = 0; k < 12 && clr_left != 0; k++) begin
            if (clr_busy) busy_cycles++;
            step();
        end
        chk("clr_len", 32'(busy_cycles), 32'd8);
        #1;
        chk("clr_exit_dirty", 32'(dirty), 32'h0);
        chk("clr_exit_r3", 32'(r3), 32'h0);
        step();
        idle_in();
        #1;
        chk("held_r0", 32'(r0), 32'hFFFF);
        chk("held_cnt", 32'(wr_cnt), 32'd1);
        step();

        // Write and clear request in the same cycle
        wr_valid = 1; wr_addr = 2; wr_data = 16'h0055; clr_req = 1; step();
        idle_in();
        #1 chk("same_r2", 32'(r2), 32'h0055);
        for (int k = 0; k < 8; k++) step();
        #1 chk("same_r2_final", 32'(r2), 32'h0);
        step();

        // Reset on the 4th CLEAR cycle
        wr_valid = 1; wr_addr = 6; wr_data = 16'hBEEF; step();
        idle_in(); clr_req = 1; step();
        clr_req = 0;
        repeat (3) step();
        rst = 1; step();
        rst = 0;
        #1;
        chk("abort_busy", 32'(clr_busy), 32'h0);
        chk("abort_ready", 32'(wr_ready), 32'h1);
        chk("abort_r6", 32'(r6), 32'h0);
        step();

        // Counter saturation
        for (int k = 0; k < 300; k++) begin
            wr_valid = 1; wr_addr = 3'($urandom); wr_data = 16'($urandom); step();
        end
        idle_in();
        #1 chk("sat_cnt", 32'(wr_cnt), 32'd255);
        step();

        // Bypass visibility in the acceptance cycle
        old5 = m_reg[5];
        wr_valid = 1; wr_addr = 5; wr_data = 16'h0F0F;
        #1;
`ifdef REG_BANK_BYPASS_EN
        chk("bypass_r5", 32'(r5), 32'h0F0F);
`else
        chk("nobypass_r5", 32'(r5), 32'(old5));
`endif
        step();
        idle_in(); step();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 63) == 0);
            clr_req  = ($urandom_range(0, 15) == 0);
            if (clr_left == 0 || !wr_valid) begin
                wr_valid = $urandom_range(0, 1) == 1;
                wr_addr  = 3'($urandom);
                wr_data  = 16'($urandom);
            end
            step();
        end
        idle_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
